// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared encodings and helpers for the zoom configuration controller
package zoom_pkg;

  localparam logic [1:0] ALG_NN = 2'd0;
  localparam logic [1:0] ALG_PR = 2'd1;
  localparam logic [1:0] ALG_DC = 2'd2;
  localparam logic [1:0] ALG_BA = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_UPDATE = 2'd2
  } zoom_state_e;

  function automatic logic is_upscale(input logic [1:0] alg);
    return (alg == ALG_NN) || (alg == ALG_PR);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector on a pre-synchronised button level
module edge_pulse (
  input  logic clk,
  input  logic resetn,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // Previous sample clears to 0, so a level held through reset fires once after release
  always_ff @(posedge clk) begin
    if (!resetn) r_prev <= 1'b0;
    else         r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/zoom_config_controller.sv
// rtl/zoom_config_controller.sv - shadow zoom config committed to active outputs when the scaler is idle
module zoom_config_controller
  import zoom_pkg::*;
#(
  parameter int IMG_WIDTH_IN   = 160,
  parameter int IMG_HEIGHT_IN  = 120,
  parameter int W_WIDTH        = 11,
  parameter int H_WIDTH        = 10,
  parameter int MAX_UP_SHIFT   = 3,
  parameter int MAX_DOWN_SHIFT = 2,
  parameter int SHIFT_W        = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               SELECT,
  input  logic               ZOOM_IN,
  input  logic               ZOOM_OUT,
  input  logic               BUSY,
  output logic [1:0]         ALGORITHM,
  output logic [SHIFT_W-1:0] SHIFT_FACTOR,
  output logic [W_WIDTH-1:0] IMG_WIDTH_OUT,
  output logic [H_WIDTH-1:0] IMG_HEIGHT_OUT,
  output logic               CFG_UPDATE,
  output logic               PENDING
);

  if ((IMG_WIDTH_IN << MAX_UP_SHIFT) >= (1 << W_WIDTH)) begin : g_chk_w
    $error("IMG_WIDTH_IN << MAX_UP_SHIFT does not fit W_WIDTH");
  end
  if ((IMG_HEIGHT_IN << MAX_UP_SHIFT) >= (1 << H_WIDTH)) begin : g_chk_h
    $error("IMG_HEIGHT_IN << MAX_UP_SHIFT does not fit H_WIDTH");
  end
  if (((IMG_WIDTH_IN >> MAX_DOWN_SHIFT) < 1) || ((IMG_HEIGHT_IN >> MAX_DOWN_SHIFT) < 1)) begin : g_chk_dn
    $error("downscaled image collapses to zero size");
  end
  if ((MAX_UP_SHIFT >= (1 << SHIFT_W)) || (MAX_DOWN_SHIFT >= (1 << SHIFT_W))) begin : g_chk_s
    $error("SHIFT_W too narrow for the maximum shift");
  end

  localparam logic [W_WIDTH-1:0] LP_W_IN   = W_WIDTH'(IMG_WIDTH_IN);
  localparam logic [H_WIDTH-1:0] LP_H_IN   = H_WIDTH'(IMG_HEIGHT_IN);
  localparam logic [SHIFT_W-1:0] LP_UP_MAX = SHIFT_W'(MAX_UP_SHIFT);
  localparam logic [SHIFT_W-1:0] LP_DN_MAX = SHIFT_W'(MAX_DOWN_SHIFT);

  logic w_sel_p, w_in_p, w_out_p;

  edge_pulse u_sel (.clk(CLK), .resetn(RESET_N), .i_level(SELECT),   .o_pulse(w_sel_p));
  edge_pulse u_in  (.clk(CLK), .resetn(RESET_N), .i_level(ZOOM_IN),  .o_pulse(w_in_p));
  edge_pulse u_out (.clk(CLK), .resetn(RESET_N), .i_level(ZOOM_OUT), .o_pulse(w_out_p));

  logic [1:0]         r_sh_alg;
  logic [SHIFT_W-1:0] r_sh_shift;
  logic [SHIFT_W-1:0] w_max_shift;

  assign w_max_shift = is_upscale(r_sh_alg) ? LP_UP_MAX : LP_DN_MAX;

  // SELECT wins over ZOOM_IN wins over ZOOM_OUT; losers in the same cycle are dropped
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_sh_alg   <= ALG_NN;
      r_sh_shift <= '0;
    end else if (w_sel_p) begin
      r_sh_alg   <= r_sh_alg + 2'd1;
      r_sh_shift <= SHIFT_W'(1);
    end else if (w_in_p) begin
      if (r_sh_shift < w_max_shift) r_sh_shift <= r_sh_shift + SHIFT_W'(1);
    end else if (w_out_p) begin
      if (r_sh_shift != '0) r_sh_shift <= r_sh_shift - SHIFT_W'(1);
    end
  end

  logic [W_WIDTH-1:0] w_width_next;
  logic [H_WIDTH-1:0] w_height_next;

  always_comb begin
    w_width_next  = LP_W_IN;
    w_height_next = LP_H_IN;
    if (is_upscale(r_sh_alg)) begin
      w_width_next  = LP_W_IN << r_sh_shift;
      w_height_next = LP_H_IN << r_sh_shift;
    end else begin
      w_width_next  = LP_W_IN >> r_sh_shift;
      w_height_next = LP_H_IN >> r_sh_shift;
    end
  end

  zoom_state_e        r_state;
  logic [1:0]         r_alg;
  logic [SHIFT_W-1:0] r_shift;
  logic [W_WIDTH-1:0] r_width;
  logic [H_WIDTH-1:0] r_height;
  logic               w_pending;

  assign w_pending = {r_sh_alg, r_sh_shift} != {r_alg, r_shift};

  // Shadow changes seen while in WAIT ride along with the commit that BUSY releases
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_alg    <= ALG_NN;
      r_shift  <= '0;
      r_width  <= LP_W_IN;
      r_height <= LP_H_IN;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pending) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!BUSY) begin
            r_alg    <= r_sh_alg;
            r_shift  <= r_sh_shift;
            r_width  <= w_width_next;
            r_height <= w_height_next;
            r_state  <= ST_UPDATE;
          end
        end
        ST_UPDATE: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign ALGORITHM      = r_alg;
  assign SHIFT_FACTOR   = r_shift;
  assign IMG_WIDTH_OUT  = r_width;
  assign IMG_HEIGHT_OUT = r_height;
  assign CFG_UPDATE     = (r_state == ST_UPDATE);
  assign PENDING        = w_pending;

endmodule

// File: tb/tb_zoom_config_controller.sv
// tb/tb_zoom_config_controller.sv - directed self-checking bench for zoom_config_controller
module tb_zoom_config_controller;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        SELECT = 1'b0;
  logic        ZOOM_IN = 1'b0;
  logic        ZOOM_OUT = 1'b0;
  logic        BUSY = 1'b0;
  logic [1:0]  ALGORITHM;
  logic [1:0]  SHIFT_FACTOR;
  logic [10:0] IMG_WIDTH_OUT;
  logic [9:0]  IMG_HEIGHT_OUT;
  logic        CFG_UPDATE;
  logic        PENDING;

  int n_total = 0;
  int n_bad   = 0;
  int cfg_cnt = 0;
  int base;

  always #5 CLK = ~CLK;

  zoom_config_controller dut (
    .CLK(CLK), .RESET_N(RESET_N), .SELECT(SELECT), .ZOOM_IN(ZOOM_IN), .ZOOM_OUT(ZOOM_OUT),
    .BUSY(BUSY), .ALGORITHM(ALGORITHM), .SHIFT_FACTOR(SHIFT_FACTOR),
    .IMG_WIDTH_OUT(IMG_WIDTH_OUT), .IMG_HEIGHT_OUT(IMG_HEIGHT_OUT),
    .CFG_UPDATE(CFG_UPDATE), .PENDING(PENDING)
  );

  always @(negedge CLK) if (CFG_UPDATE === 1'b1) cfg_cnt = cfg_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; SELECT = 1'b0; ZOOM_IN = 1'b0; ZOOM_OUT = 1'b0; BUSY = 1'b0;
    step(2);
    RESET_N = 1'b1;
    step(1);
  endtask

  // which: 0=SELECT 1=ZOOM_IN 2=ZOOM_OUT; held across exactly one rising edge, then settled
  task automatic press(input int which, input int settle);
    case (which)
      0: SELECT = 1'b1;
      1: ZOOM_IN = 1'b1;
      default: ZOOM_OUT = 1'b1;
    endcase
    step(1);
    SELECT = 1'b0; ZOOM_IN = 1'b0; ZOOM_OUT = 1'b0;
    step(settle);
  endtask

  task automatic check_out(input string tag, input int alg, input int sh, input int w, input int h);
    check({tag, "_alg"},   32'(ALGORITHM),      32'(alg));
    check({tag, "_shift"}, 32'(SHIFT_FACTOR),   32'(sh));
    check({tag, "_w"},     32'(IMG_WIDTH_OUT),  32'(w));
    check({tag, "_h"},     32'(IMG_HEIGHT_OUT), 32'(h));
  endtask

  initial begin
    step(2);
    check_out("rst", 0, 0, 160, 120);
    check("rst_cfg",  32'(CFG_UPDATE), 0);
    check("rst_pend", 32'(PENDING), 0);
    RESET_N = 1'b1;
    step(1);

    // single ZOOM_IN with cycle-accurate commit timing
    base = cfg_cnt;
    ZOOM_IN = 1'b1;
    step(1);
    ZOOM_IN = 1'b0;
    check("t1_pend_k", 32'(PENDING), 1);
    check("t1_shift_k", 32'(SHIFT_FACTOR), 0);
    step(1);
    check("t1_cfg_k1", 32'(CFG_UPDATE), 0);
    check("t1_shift_k1", 32'(SHIFT_FACTOR), 0);
    step(1);
    check_out("t1_k2", 0, 1, 320, 240);
    check("t1_cfg_k2", 32'(CFG_UPDATE), 1);
    check("t1_pend_k2", 32'(PENDING), 0);
    step(1);
    check("t1_cfg_k3", 32'(CFG_UPDATE), 0);
    check("t1_ncfg", 32'(cfg_cnt - base), 1);

    // NN saturation up and down
    do_reset();
    base = cfg_cnt;
    repeat (4) press(1, 4);
    check_out("t2_up", 0, 3, 1280, 960);
    check("t2_up_ncfg", 32'(cfg_cnt - base), 3);
    base = cfg_cnt;
    repeat (5) press(2, 4);
    check_out("t2_dn", 0, 0, 160, 120);
    check("t2_dn_ncfg", 32'(cfg_cnt - base), 3);

    // NN -> PR -> DC, then DC zoom with saturation at 2
    press(0, 4);
    check_out("t3_pr", 1, 1, 320, 240);
    press(0, 4);
    check_out("t3_dc", 2, 1, 80, 60);
    press(1, 4);
    check_out("t3_dc2", 2, 2, 40, 30);
    base = cfg_cnt;
    press(1, 4);
    check_out("t3_sat", 2, 2, 40, 30);
    check("t3_sat_ncfg", 32'(cfg_cnt - base), 0);
    check("t3_sat_pend", 32'(PENDING), 0);

    // commits held off by BUSY and merged into one
    do_reset();
    base = cfg_cnt;
    BUSY = 1'b1;
    press(1, 2);
    press(0, 3);
    check("t4_pend", 32'(PENDING), 1);
    check_out("t4_hold", 0, 0, 160, 120);
    check("t4_hold_ncfg", 32'(cfg_cnt - base), 0);
    BUSY = 1'b0;
    step(1);
    check_out("t4_commit", 1, 1, 320, 240);
    check("t4_cfg", 32'(CFG_UPDATE), 1);
    step(4);
    check("t4_ncfg", 32'(cfg_cnt - base), 1);
    check("t4_pend_end", 32'(PENDING), 0);

    // SELECT and ZOOM_IN together: only SELECT acts
    do_reset();
    SELECT = 1'b1;
    ZOOM_IN = 1'b1;
    step(1);
    SELECT = 1'b0;
    ZOOM_IN = 1'b0;
    step(4);
    check_out("t5", 1, 1, 320, 240);

    // reset while a commit is waiting on BUSY
    do_reset();
    BUSY = 1'b1;
    press(1, 2);
    check("t6_pend", 32'(PENDING), 1);
    RESET_N = 1'b0;
    step(1);
    check("t6_rst_pend", 32'(PENDING), 0);
    check("t6_rst_cfg", 32'(CFG_UPDATE), 0);
    base = cfg_cnt;
    RESET_N = 1'b1;
    BUSY = 1'b0;
    step(5);
    check_out("t6_after", 0, 0, 160, 120);
    check("t6_ncfg", 32'(cfg_cnt - base), 0);
    check("t6_pend_after", 32'(PENDING), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/zoom_config_controller.md
# zoom_config_controller

Parametrised successor to the single-button zoom controller. It holds a shadow (requested) scaling configuration driven by edge-detected SELECT / ZOOM_IN / ZOOM_OUT buttons. It commits that configuration to the active outputs only when the scaling datapath reports idle, announcing each commit with a one-cycle CFG_UPDATE. Sits between the board button synchronisers and the scaler/VGA address generator, and supplies the algorithm, shift factor and output image dimensions.

## Interface
- IMG_WIDTH_IN, 160, source image width in pixels
- IMG_HEIGHT_IN, 120, source image height in pixels
- W_WIDTH, 11, width of IMG_WIDTH_OUT
- H_WIDTH, 10, width of IMG_HEIGHT_OUT
- MAX_UP_SHIFT, 3, maximum shift for NN/PR (8x)
- MAX_DOWN_SHIFT, 2, maximum shift for DC/BA (1/4)
- SHIFT_W, 2, width of SHIFT_FACTOR; must hold max(MAX_UP_SHIFT, MAX_DOWN_SHIFT)
- CLK  in  1  system clock
- RESET_N  in  1  reset, synchronous, active-low
- SELECT  in  1  algorithm-cycle button, pre-synchronised level
- ZOOM_IN  in  1  zoom-in button, pre-synchronised level
- ZOOM_OUT  in  1  zoom-out button, pre-synchronised level
- BUSY  in  1  scaler datapath mid-frame; commits blocked while high
- ALGORITHM  out  2  active algorithm: NN=0, PR=1, DC=2, BA=3
- SHIFT_FACTOR  out  SHIFT_W  active shift
- IMG_WIDTH_OUT  out  W_WIDTH  active output width
- IMG_HEIGHT_OUT  out  H_WIDTH  active output height
- CFG_UPDATE  out  1  one-cycle pulse: active outputs changed this cycle
- PENDING  out  1  shadow config differs from active config

## Operation
- One clock domain (CLK). Reset is synchronous and active-low (RESET_N).
- Each button input passes through a rising-edge detector: the previous-sample register is reset to 0, so an input held high through reset produces a pulse on the first cycle after reset deasserts.
- Shadow regs: sh_alg and sh_shift.
  - SELECT pulse: sh_alg cycles NN→PR→DC→BA→NN; sh_shift is set to 1.
  - ZOOM_IN pulse: sh_shift increments and saturates at the mode maximum (MAX_UP_SHIFT for NN/PR, MAX_DOWN_SHIFT for DC/BA).
  - ZOOM_OUT pulse: sh_shift decrements and saturates at 0.
  - Priority when pulses coincide: SELECT over ZOOM_IN over ZOOM_OUT. Lower-priority pulses in the same cycle are dropped.
- Dimensions are computed from the shadow and registered at commit. When shift is 0, output equals input.
  - NN/PR: IN << shift.
  - DC/BA: IN >> shift, floor.
  - Elaboration check: IMG_WIDTH_IN << MAX_UP_SHIFT must fit W_WIDTH, and the same for height/H_WIDTH. IMG_*_IN >> MAX_DOWN_SHIFT must be ≥ 1.
- FSM states:
  - IDLE: go to WAIT when PENDING.
  - WAIT: stay while BUSY=1. When BUSY=0, load the active registers from the shadow and go to UPDATE.
  - UPDATE: CFG_UPDATE=1, then go to IDLE.
- Shadow may change in any state. A change during WAIT is picked up by that commit. A change during UPDATE causes a further commit round.
- PENDING is combinational: (sh_alg,sh_shift) != (ALGORITHM,SHIFT_FACTOR).

## Timing
- Reset values: ALGORITHM=NN, SHIFT_FACTOR=0, IMG_WIDTH_OUT=IMG_WIDTH_IN, IMG_HEIGHT_OUT=IMG_HEIGHT_IN, CFG_UPDATE=0, PENDING=0. Shadow equals active; state IDLE.
- Button input rises before edge k → shadow updated at edge k.
- With BUSY=0 throughout:
  - FSM in WAIT after edge k+1.
  - Active outputs updated at edge k+2.
  - CFG_UPDATE high for cycle k+2..k+3.
- BUSY sampled each cycle in WAIT; the commit occurs at the first edge where BUSY=0.
- All active outputs change on the same edge. There are no glitches between commits.
- Reset mid-operation: on the next edge, all state returns to reset values and any pending commit is discarded.

## Structure
- zoom_pkg: algorithm encodings ALG_NN/PR/DC/BA, FSM state enum (ST_IDLE, ST_WAIT, ST_UPDATE), and is_upscale(alg) helper.
- Sub-module edge_pulse: registered rising-edge detector with synchronous active-low reset, instantiated three times.
- Top module holds the shadow regs, FSM, active regs and dimension arithmetic.

## Test plan
- Reset, BUSY=0, one ZOOM_IN pulse → two edges later SHIFT_FACTOR=1, IMG_WIDTH_OUT=320, IMG_HEIGHT_OUT=240; one CFG_UPDATE pulse.
- NN, four ZOOM_IN pulses → SHIFT_FACTOR saturates at 3, output 1280x960. Then five ZOOM_OUT pulses → 0, output 160x120.
- Two SELECT pulses (NN→PR→DC), BUSY=0 → ALGORITHM=2, SHIFT_FACTOR=1, output 80x60. One ZOOM_IN → 40x30; a further ZOOM_IN holds 40x30.
- BUSY=1; ZOOM_IN then SELECT pulses → PENDING=1 and outputs unchanged. Drop BUSY → single commit with ALGORITHM=PR, SHIFT_FACTOR=1, 320x240, and exactly one CFG_UPDATE.
- SELECT and ZOOM_IN in the same cycle → only the algorithm advances; shift=1.
- ZOOM_IN pulse, then RESET_N low while the FSM is in WAIT with BUSY=1 → all outputs at reset values, no CFG_UPDATE after reset releases.
